// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive pair.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic int baud_divide(input int main_clk, input int baud);
        return main_clk / baud;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled rx line, centre sampling, valid/ready byte output
// with single-cycle framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int MAIN_CLK = 100000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int BAUD_DIVIDE = baud_divide(MAIN_CLK, BAUD);
    localparam int HALF_DIVIDE = BAUD_DIVIDE / 2;
    localparam int DIV_W       = $clog2(BAUD_DIVIDE + 1);

    localparam logic [DIV_W-1:0] HALF_CNT = DIV_W'(HALF_DIVIDE);
    // div is cleared on the sample cycle itself, so successive samples sit
    // exactly BAUD_DIVIDE clocks apart when the compare is at BAUD_DIVIDE-1.
    localparam logic [DIV_W-1:0] BIT_CNT  = DIV_W'(BAUD_DIVIDE - 1);

    uart_state_t      state;
    uart_state_t      next_state;
    logic             rx_sync;
    logic             rx_prev;
    logic [DIV_W-1:0] div;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             fall;
    logic             half_hit;
    logic             bit_hit;
    logic             stop_sample;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_sync)
    );

    assign fall        = rx_prev & ~rx_sync;
    assign half_hit    = (div == HALF_CNT);
    assign bit_hit     = (div == BIT_CNT);
    assign stop_sample = (state == STOP) && bit_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (fall) next_state = START;
            START:   if (half_hit) next_state = rx_sync ? IDLE : DATA;
            DATA:    if (bit_hit && bit_idx == 3'd7) next_state = STOP;
            STOP:    if (bit_hit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev        <= 1'b1;
            div            <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            frame_err      <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            rx_prev   <= rx_sync;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (state != next_state || (state == DATA && bit_hit)) begin
                div <= '0;
            end else begin
                div <= div + 1'b1;
            end

            if (state == START) begin
                bit_idx <= '0;
            end else if (state == DATA && bit_hit) begin
                shift   <= {rx_sync, shift[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end

            // A pending byte being consumed this edge frees the buffer for the new one.
            if (stop_sample && rx_sync && (!data_out_valid || data_out_ready)) begin
                data_out       <= shift;
                data_out_valid <= 1'b1;
            end else if (data_out_valid && data_out_ready) begin
                data_out_valid <= 1'b0;
            end

            if (stop_sample && !rx_sync) begin
                frame_err <= 1'b1;
            end
            if (stop_sample && rx_sync && data_out_valid && !data_out_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at MAIN_CLK=16, BAUD=1 (16 clocks per bit).
module tb_uart_rx;

    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       frame_err;
    logic       overrun;

    uart_rx #(.MAIN_CLK(16), .BAUD(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx             (rx),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .frame_err      (frame_err),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation of the output side, sampled on the falling edge.
    logic [7:0] got_q[$];
    int   fe_cnt = 0, ov_cnt = 0, both_cnt = 0, vcyc_cnt = 0, rise_cnt = 0, rise_last = 0;
    logic v_d = 1'b0;

    always @(negedge clk) begin
        if (data_out_valid && data_out_ready) got_q.push_back(data_out);
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (frame_err && overrun) both_cnt <= both_cnt + 1;
        if (data_out_valid) vcyc_cnt <= vcyc_cnt + 1;
        if (data_out_valid && !v_d) begin
            rise_cnt  <= rise_cnt + 1;
            rise_last <= cyc;
        end
        v_d <= data_out_valid;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        rx = 1'b0;
        step(BD);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(BD);
        end
        rx = stop_v;
        step(BD);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_v;
        int         exp_bytes;
        int         exp_fe;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] exp_q[$];
    int         n0, f0, o0, r0, v0, t0, exp_fe, mism;

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1, 0};
        vecs[1] = '{8'hFF, 1'b1, 1, 0};
        vecs[2] = '{8'h80, 1'b1, 1, 0};
        vecs[3] = '{8'h01, 1'b1, 1, 0};
        vecs[4] = '{8'h3C, 1'b0, 0, 1};
        vecs[5] = '{8'hE7, 1'b1, 1, 0};

        rst = 1'b1;
        rx = 1'b1;
        data_out_ready = 1'b1;
        step(3);
        check("reset_data_out", int'(data_out), 0);
        check("reset_valid", int'(data_out_valid), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_overrun", int'(overrun), 0);
        rst = 1'b0;
        step(5);

        // 0x55 with ready tied high
        r0 = rise_cnt; v0 = vcyc_cnt; f0 = fe_cnt; o0 = ov_cnt; n0 = got_q.size();
        t0 = cyc;
        send_frame(8'h55, 1'b1);
        rx = 1'b1;
        step(30);
        check("b55_count", got_q.size() - n0, 1);
        if (got_q.size() > n0) check("b55_data", int'(got_q[n0]), 8'h55);
        check("b55_rises", rise_cnt - r0, 1);
        check("b55_valid_cycles", vcyc_cnt - v0, 1);
        check_range("b55_latency", rise_last - t0, 9 * BD + BD / 2, 9 * BD + BD / 2 + 6);
        check("b55_flags", (fe_cnt - f0) + (ov_cnt - o0), 0);

        // short glitch
        r0 = rise_cnt; f0 = fe_cnt;
        rx = 1'b0;
        step(5);
        rx = 1'b1;
        step(40);
        check("glitch_valid", rise_cnt - r0, 0);
        check("glitch_frame_err", fe_cnt - f0, 0);

        // framing error followed by a held-low line
        r0 = rise_cnt; f0 = fe_cnt;
        send_frame(8'hA3, 1'b0);
        step(60);
        check("ferr_pulses", fe_cnt - f0, 1);
        check("ferr_valid", rise_cnt - r0, 0);
        rx = 1'b1;
        step(30);
        check("break_no_retrigger", fe_cnt - f0, 1);
        check("break_valid", rise_cnt - r0, 0);

        // table-driven frames
        for (int k = 0; k < 6; k++) begin
            n0 = got_q.size(); f0 = fe_cnt;
            send_frame(vecs[k].data, vecs[k].stop_v);
            rx = 1'b1;
            step(30);
            check($sformatf("vec%0d_bytes", k), got_q.size() - n0, vecs[k].exp_bytes);
            check($sformatf("vec%0d_fe", k), fe_cnt - f0, vecs[k].exp_fe);
            if (vecs[k].exp_bytes == 1 && got_q.size() > n0)
                check($sformatf("vec%0d_data", k), int'(got_q[n0]), int'(vecs[k].data));
        end

        // overrun: 0x11 then 0x22 back-to-back with ready low
        data_out_ready = 1'b0;
        n0 = got_q.size(); o0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        rx = 1'b1;
        step(30);
        check("ovr_data_held", int'(data_out), 8'h11);
        check("ovr_valid_held", int'(data_out_valid), 1);
        check("ovr_pulses", ov_cnt - o0, 1);
        data_out_ready = 1'b1;
        step(20);
        check("ovr_drain_count", got_q.size() - n0, 1);
        if (got_q.size() > n0) check("ovr_drain_data", int'(got_q[n0]), 8'h11);
        check("ovr_valid_dropped", int'(data_out_valid), 0);

        // reset during bit 4 of a frame while a byte is pending
        data_out_ready = 1'b0;
        send_frame(8'h5A, 1'b1);
        rx = 1'b1;
        step(20);
        check("pre_rst_valid", int'(data_out_valid), 1);
        rx = 1'b0;
        step(BD);
        step(4 * BD);
        rx = 1'b1;
        step(8);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst_data_out", int'(data_out), 0);
        check("midrst_valid", int'(data_out_valid), 0);
        check("midrst_flags", int'(frame_err) + int'(overrun), 0);
        step(30);
        data_out_ready = 1'b1;
        n0 = got_q.size(); f0 = fe_cnt;
        send_frame(8'hC3, 1'b1);
        rx = 1'b1;
        step(30);
        check("post_rst_count", got_q.size() - n0, 1);
        if (got_q.size() > n0) check("post_rst_data", int'(got_q[n0]), 8'hC3);
        check("post_rst_fe", fe_cnt - f0, 0);

        // randomized frames against a frame-level model
        exp_q.delete();
        exp_fe = 0;
        n0 = got_q.size(); f0 = fe_cnt;
        for (int k = 0; k < 24; k++) begin
            logic [7:0] b;
            logic       good;
            int         gap;
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            gap  = $urandom_range(0, 12);
            // after a bad stop bit the line must go high again before a new start can be seen
            if (!good && gap < 2) gap = 2;
            if (good) exp_q.push_back(b);
            else exp_fe++;
            send_frame(b, good);
            rx = 1'b1;
            step(gap);
        end
        step(40);
        check("rand_count", got_q.size() - n0, exp_q.size());
        check("rand_fe", fe_cnt - f0, exp_fe);
        mism = 0;
        for (int k = 0; k < exp_q.size(); k++)
            if (n0 + k >= got_q.size() || got_q[n0 + k] != exp_q[k]) mism++;
        check("rand_data", mism, 0);

        // back-to-back 0x00..0xFF at full rate
        n0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt;
        for (int k = 0; k < 256; k++) send_frame(8'(k), 1'b1);
        rx = 1'b1;
        step(40);
        check("loop_count", got_q.size() - n0, 256);
        mism = 0;
        for (int k = 0; k < 256; k++)
            if (n0 + k >= got_q.size() || int'(got_q[n0 + k]) != k) mism++;
        check("loop_order", mism, 0);
        check("loop_fe", fe_cnt - f0, 0);
        check("loop_ovr", ov_cnt - o0, 0);

        check("flags_exclusive", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
